// File: rtl/aes_pkg.sv
// aes_pkg: shared types and helpers for the sequential AES key-expansion engine.
// Contents: FSM state enum, NK/NR derivation, GF(2^8) xtime, S-box ROM, RotWord/SubWord.
// Pure declarations; no ports, no state.
package aes_pkg;

  typedef enum logic [2:0] {
    IDLE,
    KEY,
    PREP,
    SUB,
    XOR,
    OUT,
    DONE
  } ks_state_t;

  function automatic int nk_of(input int key_bits);
    return key_bits / 32;
  endfunction

  function automatic int nr_of(input int key_bits);
    return key_bits / 32 + 6;
  endfunction

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1; 0x80 -> 0x1b.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // S-box ROM: one 16-byte row per high nibble, byte 0 of the row is the MSB.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [127:0] row;
    case (a[7:4])
      4'h0:    row = 128'h637c777bf26b6fc53001672bfed7ab76;
      4'h1:    row = 128'hca82c97dfa5947f0add4a2af9ca472c0;
      4'h2:    row = 128'hb7fd9326363ff7cc34a5e5f171d83115;
      4'h3:    row = 128'h04c723c31896059a071280e2eb27b275;
      4'h4:    row = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
      4'h5:    row = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
      4'h6:    row = 128'hd0efaafb434d338545f9027f503c9fa8;
      4'h7:    row = 128'h51a3408f929d38f5bcb6da2110fff3d2;
      4'h8:    row = 128'hcd0c13ec5f974417c4a77e3d645d1973;
      4'h9:    row = 128'h60814fdc222a908846eeb814de5e0bdb;
      4'ha:    row = 128'he0323a0a4906245cc2d3ac629195e479;
      4'hb:    row = 128'he7c8376d8dd54ea96c56f4ea657aae08;
      4'hc:    row = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
      4'hd:    row = 128'h703eb5664803f60e613557b986c11d9e;
      4'he:    row = 128'he1f8981169d98e949b1e87e9ce5528df;
      default: row = 128'h8ca1890dbfe6426841992d0fb054bb16;
    endcase
    return row[{~a[3:0], 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational AES forward S-box, 8 bits in, 8 bits out.
// Latency: 0 cycles (pure ROM lookup). No handshake, no backpressure.
// Ports: a_i input byte, s_o substituted byte.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a_i,
  output logic [7:0] s_o
);

  assign s_o = sbox(a_i);

endmodule

// File: rtl/aes_key_expand_seq.sv
// aes_key_expand_seq: sequential AES-128/192/256 key expansion, one 32-bit word per handshake.
// Latency: key words 1/cycle; derived words 3 cycles, +4 (byte-serial) or +1 (parallel) with SubWord.
// Backpressure: out_valid/out_ready; word held stable until accepted, engine stalls meanwhile.
// Ports: clk, rst (async high); start/key_in launch; busy, done status;
//        out_valid/out_ready/out_word/out_idx carry w[out_idx].
module aes_key_expand_seq
  import aes_pkg::*;
#(
  parameter int KEY_BITS    = 256,
  parameter int BYTE_SERIAL = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [KEY_BITS-1:0] key_in,
  output logic                busy,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_word,
  output logic [5:0]          out_idx,
  output logic                done
);

  localparam int         NK       = nk_of(KEY_BITS);
  localparam int         NR       = nr_of(KEY_BITS);
  localparam logic [5:0] LAST_IDX = 6'(4 * NR + 3);
  localparam logic [2:0] NK_M1    = 3'(NK - 1);

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key
    $error("aes_key_expand_seq: KEY_BITS must be 128, 192 or 256");
  end

  ks_state_t   state_q, state_d;
  logic [31:0] win_q [NK];
  logic [31:0] win_d [NK];
  logic [31:0] temp_q, temp_d;
  logic [5:0]  i_q, i_d;
  // i mod NK, tracked separately because NK=6 is not a power of two.
  logic [2:0]  kmod_q, kmod_d;
  logic [7:0]  rcon_q, rcon_d;
  logic [1:0]  sub_cnt_q, sub_cnt_d;
  logic        out_vld_q, out_vld_d;
  logic [31:0] out_word_q, out_word_d;
  logic [5:0]  out_idx_q, out_idx_d;
  logic [31:0] sub_res;
  logic [31:0] new_word;

  // SubWord datapath: byte-serial rewrites one byte of temp per cycle, MSB first.
  if (BYTE_SERIAL != 0) begin : g_serial
    logic [7:0] sb_in;
    logic [7:0] sb_out;
    assign sb_in = temp_q[{sub_cnt_q, 3'b000} +: 8];
    aes_sbox u_sbox (.a_i(sb_in), .s_o(sb_out));
    always_comb begin
      sub_res = temp_q;
      sub_res[{sub_cnt_q, 3'b000} +: 8] = sb_out;
    end
  end else begin : g_parallel
    for (genvar b = 0; b < 4; b++) begin : g_sb
      aes_sbox u_sbox (.a_i(temp_q[8*b +: 8]), .s_o(sub_res[8*b +: 8]));
    end
  end

  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    temp_d     = temp_q;
    i_d        = i_q;
    kmod_d     = kmod_q;
    rcon_d     = rcon_q;
    sub_cnt_d  = sub_cnt_q;
    out_vld_d  = out_vld_q;
    out_word_d = out_word_q;
    out_idx_d  = out_idx_q;
    new_word   = win_q[0] ^ temp_q ^ ((kmod_q == 3'd0) ? {rcon_q, 24'h0} : 32'h0);

    case (state_q)
      IDLE: begin
        if (start) begin
          for (int j = 0; j < NK; j++) win_d[j] = key_in[KEY_BITS-1-32*j -: 32];
          out_word_d = key_in[KEY_BITS-1 -: 32];
          out_idx_d  = '0;
          out_vld_d  = 1'b1;
          i_d        = '0;
          kmod_d     = '0;
          rcon_d     = 8'h01;
          state_d    = KEY;
        end
      end
      KEY: begin
        // Rotate the window on each accept so the next key word is always in win[1];
        // after NK accepts it is back in its original order.
        if (out_ready) begin
          for (int j = 0; j < NK - 1; j++) win_d[j] = win_q[j+1];
          win_d[NK-1] = win_q[0];
          i_d = i_q + 6'd1;
          if (kmod_q == NK_M1) begin
            kmod_d    = '0;
            out_vld_d = 1'b0;
            state_d   = PREP;
          end else begin
            kmod_d     = kmod_q + 3'd1;
            out_word_d = win_q[1];
            out_idx_d  = i_q + 6'd1;
          end
        end
      end
      PREP: begin
        sub_cnt_d = 2'd3;
        if (kmod_q == 3'd0) begin
          temp_d  = rot_word(win_q[NK-1]);
          state_d = SUB;
        end else begin
          temp_d  = win_q[NK-1];
          // AES-256 applies SubWord alone halfway through each 8-word group.
          state_d = (NK == 8 && kmod_q == 3'd4) ? SUB : XOR;
        end
      end
      SUB: begin
        temp_d    = sub_res;
        sub_cnt_d = sub_cnt_q - 2'd1;
        if (BYTE_SERIAL == 0 || sub_cnt_q == 2'd0) state_d = XOR;
      end
      XOR: begin
        if (kmod_q == 3'd0) rcon_d = xtime(rcon_q);
        out_word_d = new_word;
        out_idx_d  = i_q;
        out_vld_d  = 1'b1;
        state_d    = OUT;
      end
      OUT: begin
        if (out_ready) begin
          for (int j = 0; j < NK - 1; j++) win_d[j] = win_q[j+1];
          win_d[NK-1] = out_word_q;
          i_d         = i_q + 6'd1;
          kmod_d      = (kmod_q == NK_M1) ? 3'd0 : kmod_q + 3'd1;
          out_vld_d   = 1'b0;
          state_d     = (i_q == LAST_IDX) ? DONE : PREP;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      for (int j = 0; j < NK; j++) win_q[j] <= '0;
      temp_q     <= '0;
      i_q        <= '0;
      kmod_q     <= '0;
      rcon_q     <= 8'h01;
      sub_cnt_q  <= '0;
      out_vld_q  <= 1'b0;
      out_word_q <= '0;
      out_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      temp_q     <= temp_d;
      i_q        <= i_d;
      kmod_q     <= kmod_d;
      rcon_q     <= rcon_d;
      sub_cnt_q  <= sub_cnt_d;
      out_vld_q  <= out_vld_d;
      out_word_q <= out_word_d;
      out_idx_q  <= out_idx_d;
    end
  end

  assign busy      = (state_q != IDLE) && (state_q != DONE);
  assign done      = (state_q == DONE);
  assign out_valid = out_vld_q;
  assign out_word  = out_word_q;
  assign out_idx   = out_idx_q;

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Bench for aes_key_expand_seq: six instances (128/192/256 x serial/parallel), run one at a time.
// Expected words come from an independent GF(2^8)-derived reference plus published anchor words.
// A monitor pops the scoreboard on every accepted word and checks payload stability during stalls.
module tb_aes_key_expand_seq;

  localparam int NI = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         start_s [NI];
  logic [255:0] key_s   [NI];
  logic         rdy_s   [NI];
  logic         busy_s  [NI];
  logic         vld_s   [NI];
  logic         done_s  [NI];
  logic [31:0]  word_s  [NI];
  logic [5:0]   idx_s   [NI];

  int ntests = 0;
  int nfail  = 0;
  int cyc    = 0;
  int sel    = 0;
  int rand_rdy = 0;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int KB = (g % 3 == 0) ? 128 : ((g % 3 == 1) ? 192 : 256);
    localparam int BS = (g < 3) ? 1 : 0;
    logic        busy_w, vld_w, done_w;
    logic [31:0] word_w;
    logic [5:0]  idx_w;
    aes_key_expand_seq #(.KEY_BITS(KB), .BYTE_SERIAL(BS)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start_s[g]),
      .key_in    (key_s[g][KB-1:0]),
      .busy      (busy_w),
      .out_valid (vld_w),
      .out_ready (rdy_s[g]),
      .out_word  (word_w),
      .out_idx   (idx_w),
      .done      (done_w)
    );
    assign busy_s[g] = busy_w;
    assign vld_s[g]  = vld_w;
    assign done_s[g] = done_w;
    assign word_s[g] = word_w;
    assign idx_s[g]  = idx_w;
  end

  // ---------------- reference model ----------------
  logic [7:0]  sb_tab [256];
  logic [31:0] mw [60];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (a != 0 && gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sb_tab[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb_tab[w[31:24]], sb_tab[w[23:16]], sb_tab[w[15:8]], sb_tab[w[7:0]]};
  endfunction

  task automatic model(input logic [255:0] key, input int nk);
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < nk; i++) mw[i] = 32'(key >> (32 * (nk - 1 - i)));
    for (int i = nk; i < 4 * (nk + 7); i++) begin
      t = mw[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end else if (nk == 8 && i % nk == 4) begin
        t = subw(t);
      end
      mw[i] = mw[i-nk] ^ t;
    end
  endtask

  // Published FIPS-197 words; they override the model where known.
  function automatic logic [31:0] anchor(input int nk, input int i, input logic [31:0] dflt);
    case (nk * 64 + i)
      4*64+4:  return 32'ha0fafe17;
      4*64+5:  return 32'h88542cb1;
      4*64+6:  return 32'h23a33939;
      4*64+7:  return 32'h2a6c7605;
      4*64+43: return 32'hb6630ca6;
      6*64+6:  return 32'hfe0c91f7;
      6*64+51: return 32'h01002202;
      8*64+8:  return 32'h9ba35411;
      8*64+12: return 32'ha8b09c1a;
      8*64+59: return 32'h706c631e;
      default: return dflt;
    endcase
  endfunction

  // ---------------- checking ----------------
  logic [37:0] exp_q [$];
  logic        held_vld = 1'b0;
  logic [37:0] held;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    ntests++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  initial begin
    logic [37:0] e;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0) begin
        held_vld = 1'b0;
      end else begin
        if (held_vld)
          check($sformatf("stall_hold inst%0d", sel),
                64'({vld_s[sel], idx_s[sel], word_s[sel]}), 64'({1'b1, held}));
        held_vld = vld_s[sel] && !rdy_s[sel];
        held     = {idx_s[sel], word_s[sel]};
        if (vld_s[sel] && rdy_s[sel]) begin
          if (exp_q.size() == 0) begin
            ntests++;
            nfail++;
            $display("FAIL unexpected_word inst%0d: got idx %0d word %h, expected none",
                     sel, idx_s[sel], word_s[sel]);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("word inst%0d idx%0d", sel, e[37:32]),
                  64'({idx_s[sel], word_s[sel]}), 64'(e));
          end
        end
      end
    end
  end

  initial begin
    for (int g = 0; g < NI; g++) rdy_s[g] = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      for (int g = 0; g < NI; g++) rdy_s[g] = (rand_rdy != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic run(input int g, input logic [255:0] key, input int nk,
                     input int poke, input int abort_at, input int chk_lat);
    int   lat_exp;
    int   c0;
    int   s;
    logic got;
    logic aborted;
    model(key, nk);
    s = (g < 3) ? 4 : 1;
    lat_exp = nk;
    for (int i = nk; i < 4 * (nk + 7); i++)
      lat_exp += 3 + ((i % nk == 0 || (nk == 8 && i % nk == 4)) ? s : 0);
    for (int i = 0; i < 4 * (nk + 7); i++)
      exp_q.push_back({6'(i), anchor(nk, i, mw[i])});
    sel = g;
    @(posedge clk);
    #2;
    key_s[g]   = key;
    start_s[g] = 1'b1;
    @(posedge clk);
    #2;
    c0         = cyc;
    start_s[g] = 1'b0;
    key_s[g]   = ~key;
    got     = 1'b0;
    aborted = 1'b0;
    for (int n = 0; n < 3000 && !got; n++) begin
      @(negedge clk);
      if (n == 0) check($sformatf("busy_after_start inst%0d", g), 64'(busy_s[g]), 64'd1);
      if (done_s[g]) begin
        got = 1'b1;
      end else if (abort_at >= 0 && vld_s[g] && idx_s[g] == 6'(abort_at)) begin
        #1;
        rst = 1'b1;
        #1;
        check("reset_mid_run outputs",
              64'({busy_s[g], vld_s[g], done_s[g], idx_s[g], word_s[g]}), 64'd0);
        exp_q.delete();
        aborted = 1'b1;
        got     = 1'b1;
      end else begin
        start_s[g] = (poke != 0) && vld_s[g] && (idx_s[g] == 6'd20);
      end
    end
    start_s[g] = 1'b0;
    if (aborted) begin
      repeat (3) begin
        @(negedge clk);
        check("no_done_in_reset", 64'({done_s[g], busy_s[g]}), 64'd0);
      end
      @(posedge clk);
      #2;
      rst = 1'b0;
    end else if (!got) begin
      ntests++;
      nfail++;
      $display("FAIL done_timeout inst%0d: got no done, expected done pulse", g);
      exp_q.delete();
    end else begin
      if (chk_lat != 0) check($sformatf("latency inst%0d", g), 64'(cyc - c0), 64'(lat_exp));
      check($sformatf("words_left inst%0d", g), 64'(exp_q.size()), 64'd0);
      @(negedge clk);
      check($sformatf("done_one_cycle inst%0d", g), 64'({done_s[g], busy_s[g]}), 64'd0);
    end
  endtask

  logic [255:0] k128, k192, k256;

  initial begin
    k128 = 256'h2b7e151628aed2a6abf7158809cf4f3c;
    k192 = 256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    k256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    rst = 1'b1;
    for (int g = 0; g < NI; g++) begin
      start_s[g] = 1'b0;
      key_s[g]   = '0;
    end
    build_sbox();
    repeat (2) @(negedge clk);
    for (int g = 0; g < NI; g++)
      check($sformatf("reset_state inst%0d", g),
            64'({busy_s[g], vld_s[g], done_s[g], idx_s[g], word_s[g]}), 64'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;

    for (int g = 0; g < NI; g++)
      run(g, (g % 3 == 0) ? k128 : ((g % 3 == 1) ? k192 : k256),
          (g % 3 == 0) ? 4 : ((g % 3 == 1) ? 6 : 8), 0, -1, 1);

    rand_rdy = 1;
    run(0, k128, 4, 0, -1, 0);
    run(3, k128, 4, 0, -1, 0);
    rand_rdy = 0;
    repeat (2) @(posedge clk);

    run(0, k128, 4, 1, -1, 1);
    run(0, k128, 4, 0, 30, 0);
    run(0, k128, 4, 0, -1, 1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
